// File: rtl/arf_pkg.sv
// Shared constants for the address register file: function-select codes and
// the fixed roles of the first three register slots.
package arf_pkg;

    localparam logic [2:0] FS_DEC   = 3'b000;  // decrement
    localparam logic [2:0] FS_INC   = 3'b001;  // increment
    localparam logic [2:0] FS_LOAD  = 3'b010;  // load full word
    localparam logic [2:0] FS_CLR   = 3'b011;  // clear
    localparam logic [2:0] FS_LDL_Z = 3'b100;  // low byte, zero-extend
    localparam logic [2:0] FS_LDL_K = 3'b101;  // low byte, keep upper bits
    localparam logic [2:0] FS_LDH_K = 3'b110;  // bits [15:8], keep the rest
    localparam logic [2:0] FS_LDL_S = 3'b111;  // low byte, sign-extend

    localparam int unsigned IDX_PC = 0;
    localparam int unsigned IDX_AR = 1;
    localparam int unsigned IDX_SP = 2;

endpackage

// File: rtl/addr_reg_cell.sv
// One address register: active-low enable, FunSel decode, async reset to a
// per-instance value. at_top/at_bottom block inc/dec and raise *_held instead.
module addr_reg_cell
    import arf_pkg::*;
#(
    parameter int unsigned        DATA_W  = 16,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] d,
    input  logic              en_n,
    input  logic [2:0]        funsel,
    input  logic              at_top,
    input  logic              at_bottom,
    output logic [DATA_W-1:0] q,
    output logic              dec_held,
    output logic              inc_held
);

    localparam logic [DATA_W-1:0] LO_MASK = DATA_W'(8'hFF);
    localparam logic [DATA_W-1:0] HI_MASK = DATA_W'(16'hFF00);

    logic [DATA_W-1:0] q_next;

    // Next value for the selected operation; a blocked inc/dec keeps q.
    always_comb begin
        q_next = q;
        case (funsel)
            FS_DEC:   if (!at_bottom) q_next = q - DATA_W'(1);
            FS_INC:   if (!at_top)    q_next = q + DATA_W'(1);
            FS_LOAD:  q_next = d;
            FS_CLR:   q_next = '0;
            FS_LDL_Z: q_next = d & LO_MASK;
            FS_LDL_K: q_next = (q & ~LO_MASK) | (d & LO_MASK);
            // Narrower than 16 bits there is no upper byte to load: hold.
            FS_LDH_K: if (DATA_W >= 16) q_next = (q & ~HI_MASK) | (d & HI_MASK);
            FS_LDL_S: q_next = d[7] ? (d | ~LO_MASK) : (d & LO_MASK);
            default:  q_next = q;
        endcase
    end

    // Bound-hit events, only meaningful on an enabled edge.
    always_comb begin
        dec_held = !en_n && (funsel == FS_DEC) && at_bottom;
        inc_held = !en_n && (funsel == FS_INC) && at_top;
    end

    // Register state with async reset to the slot's reset value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (!en_n) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/param_address_register_file.sv
// Address-side register file: PC, AR, SP and optional extra registers sharing
// one input bus and FunSel, two combinational read ports, and sticky SP
// overflow/underflow flags.
module param_address_register_file
    import arf_pkg::*;
#(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       NUM_REGS  = 4,
    parameter int unsigned       SEL_W     = $clog2(NUM_REGS),
    parameter logic [DATA_W-1:0] PC_RST    = '0,
    parameter logic [DATA_W-1:0] SP_TOP    = {DATA_W{1'b1}},
    parameter logic [DATA_W-1:0] SP_BOTTOM = {{(DATA_W-8){1'b1}}, 8'h00}
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [DATA_W-1:0]   I,
    input  logic [NUM_REGS-1:0] RegSel,
    input  logic [2:0]          FunSel,
    input  logic [SEL_W-1:0]    OutCSel,
    input  logic [SEL_W-1:0]    OutDSel,
    input  logic                FlagClr,
    output logic [DATA_W-1:0]   OutC,
    output logic [DATA_W-1:0]   OutD,
    output logic                StackOvf,
    output logic                StackUnf
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] at_top;
    logic [NUM_REGS-1:0] at_bottom;
    logic [NUM_REGS-1:0] dec_held;
    logic [NUM_REGS-1:0] inc_held;
    logic                ovf_q;
    logic                unf_q;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        localparam logic [DATA_W-1:0] RV = (k == IDX_PC) ? PC_RST :
                                           (k == IDX_SP) ? SP_TOP : '0;

        // Only SP is bounded; every other slot wraps freely.
        assign at_top[k]    = (k == IDX_SP) && (regs[k] == SP_TOP);
        assign at_bottom[k] = (k == IDX_SP) && (regs[k] == SP_BOTTOM);

        addr_reg_cell #(
            .DATA_W  (DATA_W),
            .RST_VAL (RV)
        ) u_cell (
            .clock     (Clock),
            .reset     (Reset),
            .d         (I),
            .en_n      (RegSel[k]),
            .funsel    (FunSel),
            .at_top    (at_top[k]),
            .at_bottom (at_bottom[k]),
            .q         (regs[k]),
            .dec_held  (dec_held[k]),
            .inc_held  (inc_held[k])
        );
    end

    // Sticky flags; a set on the same edge as FlagClr wins. Only the SP slot
    // can raise a held event, so OR-reducing is equivalent to picking it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (|dec_held)    ovf_q <= 1'b1;
            else if (FlagClr) ovf_q <= 1'b0;
            if (|inc_held)    unf_q <= 1'b1;
            else if (FlagClr) unf_q <= 1'b0;
        end
    end

    assign StackOvf = ovf_q;
    assign StackUnf = unf_q;

    // Read muxes; a select with no matching register yields zero.
    always_comb begin
        OutC = '0;
        OutD = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (OutCSel == SEL_W'(k)) OutC = regs[k];
            if (OutDSel == SEL_W'(k)) OutD = regs[k];
        end
    end

endmodule
